// File: rtl/interrupt_controller_if.sv
// interrupt_controller_if: register bus, IME controls and CPU dispatch handshake of the interrupt controller
interface interrupt_controller_if;
  logic        cpu_en;
  logic [4:0]  irq_in;
  logic        reg_select;
  logic [7:0]  wdata;
  logic        write;
  logic [7:0]  rdata;
  logic        ei;
  logic        di;
  logic        reti;
  logic        instr_boundary;
  logic        int_req;
  logic        int_ack;
  logic [15:0] vector;
  logic        vector_valid;
  logic        wake;
  modport slave (
    input  cpu_en, irq_in, reg_select, wdata, write, ei, di, reti, instr_boundary, int_ack,
    output rdata, int_req, vector, vector_valid, wake
  );
  modport master (
    output cpu_en, irq_in, reg_select, wdata, write, ei, di, reti, instr_boundary, int_ack,
    input  rdata, int_req, vector, vector_valid, wake
  );
endinterface

// File: rtl/interrupt_controller.sv
// interrupt_controller: IF/IE latching, IME control and the 5-M-cycle CPU dispatch sequence
module interrupt_controller (
  input logic             clk,
  input logic             reset,
  interrupt_controller_if.slave bus
);
  typedef enum logic [2:0] {IDLE, D1, D2, D3, D4, D5} state_t;
  state_t      state;
  logic [4:0]  irq_flag;
  logic [7:0]  ie;
  logic        ime;
  logic        ime_pending;
  logic [4:0]  pend;
  logic [4:0]  lowest;
  logic [4:0]  next_flag;
  logic [2:0]  n;
  logic        accept;
  assign pend = irq_flag & ie[4:0];
  assign lowest = pend & (~pend + 5'd1);
  assign n = {lowest[4], lowest[3] | lowest[2], lowest[3] | lowest[1]};
  assign accept = bus.cpu_en & bus.int_ack & bus.int_req;
  assign bus.int_req = ime & (|pend) & (state == IDLE);
  assign bus.wake = |pend;
  assign bus.rdata = bus.reg_select ? ie : {3'b111, irq_flag};
  // write, then dispatch clear, then new requests, so a pulse always survives
  always_comb
    next_flag = ((bus.write & ~bus.reg_select ? bus.wdata[4:0] : irq_flag) &
                 ~(state == D3 ? lowest : 5'd0)) | bus.irq_in;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      irq_flag <= '0;
      ie <= '0;
      ime <= 1'b0;
      ime_pending <= 1'b0;
      bus.vector <= '0;
      bus.vector_valid <= 1'b0;
    end else if (bus.cpu_en) begin
      irq_flag <= next_flag;
      if (bus.write & bus.reg_select) ie <= bus.wdata;
      if (accept | bus.di) begin
        ime <= 1'b0;
        ime_pending <= 1'b0;
      end else begin
        ime <= ime | bus.reti | (ime_pending & bus.instr_boundary);
        ime_pending <= bus.ei | (ime_pending & ~bus.instr_boundary);
      end
      if (state == D3) bus.vector <= |pend ? {8'h00, 2'b01, n, 3'b000} : 16'h0000;
      bus.vector_valid <= state == D4;
      state <= accept ? D1 : (state == IDLE || state == D5) ? IDLE : state_t'(state + 3'd1);
    end
  end
endmodule

// File: doc/interrupt_controller.md
# interrupt_controller

Sink side of the peripheral interrupt lines (timer, serial, joypad, PPU). Latches request pulses into IF, masks them with IE and the master enable IME, and runs the CPU dispatch handshake: raises a request to the CPU, sequences the 5-M-cycle dispatch, and returns the resolved vector. It is mapped at IF (FF0F) and IE (FFFF) and sits between the peripherals and the CPU core.

## Interface
Parameters: none.

Ports:
- clk  input  1  system clock
- reset  input  1  reset is asynchronous and active-low (0 = reset)
- cpu_en  input  1  one-cycle strobe per CPU M-cycle; all state except reset advances only when 1
- irq_in  input  5  request pulses, sampled when cpu_en=1: [0] VBlank, [1] STAT, [2] Timer, [3] Serial, [4] Joypad
- reg_select  input  1  0 = IF, 1 = IE
- wdata  input  8  write data
- write  input  1  register write, qualified by cpu_en
- rdata  output  8  combinational read: IF → {3'b111, if[4:0]}, IE → ie[7:0]
- ei, di, reti  input  1 each  IME control pulses from the decoder, qualified by cpu_en
- instr_boundary  input  1  CPU is at an instruction boundary, qualified by cpu_en
- int_req  output  1  dispatch request to the CPU
- int_ack  input  1  CPU accepts dispatch, qualified by cpu_en
- vector  output  16  dispatch target address
- vector_valid  output  1  vector is valid this cycle
- wake  output  1  HALT wake: |(if & ie[4:0]), independent of IME

## Operation
- IF update on each cpu_en cycle, in this order: register write (bits [4:0] only; [7:5] ignored), then dispatch clear of the served bit, then OR in irq_in. A request on the same cycle as a write or clear always leaves its bit at 1.
- IE is a plain 8-bit register. Only bits [4:0] take part in masking.
- IME priority: di > reti > ei.
  - di clears ime and ime_pending.
  - reti sets ime immediately.
  - ei sets ime_pending. The first later cpu_en cycle with instr_boundary=1 moves ime_pending into ime. The net effect is that the instruction after EI always executes before any dispatch.
- int_req = ime & |(if[4:0] & ie[4:0]) & (state == IDLE). Registered inputs only; no combinational path from irq_in.
- int_ack is honored only when int_req=1 and cpu_en=1. Otherwise it is ignored.
- State machine; each transition occurs on a cpu_en cycle:
  - IDLE → D1 on an accepted int_ack. ime and ime_pending are cleared on this cycle.
  - D1 → D2 → D3: fixed wait and high-byte push cycles. No action.
  - D3 → D4: resolve the lowest set bit n of if[4:0] & ie[4:0], sampled in D3. Latch vector = 0x0040 + 8·n and clear if[n]. If no bit is set (IE or IF changed during the push), latch vector = 0x0000 and clear nothing.
  - D4 → D5: vector_valid = 1.
  - D5 → IDLE.
- ei, di and reti arriving during D1–D5 are applied normally. int_req stays 0 until IDLE.

## Timing
- Reset values: if = 0 (rdata reads 0xE0 with reg_select=0), ie = 0x00, ime = 0, ime_pending = 0, state = IDLE, vector = 0x0000, vector_valid = 0, int_req = 0, wake = 0.
- An asynchronous reset in any D-state returns to IDLE immediately.
- Request → int_req latency: 1 clk after the sampling cpu_en edge, given ime = 1 and the IE bit set.
- Ack → vector_valid: exactly 4 cpu_en strobes after the accepting strobe. vector_valid stays high only for the cpu_en period of D5.
- wake responds in the same clk cycle the IF/IE register changes. It ignores cpu_en gating of the output.
- A write to IF with a set bit is a software request and behaves exactly like a pulse.

## Test plan
- Reset, then read IF and IE → 0xE0 and 0x00. Pulse irq_in[2] with ie = 0x04 and ime = 0 → IF reads 0xE4, wake = 1, int_req = 0.
- ie = 0x1F, ime = 1, irq_in = 5'b10100 in one strobe, ack → vector 0x0050 on D5, then IF = 0xF0. Second dispatch → 0x0060.
- ack with only IF[0] pending, then write ie = 0x00 during D1 → vector 0x0000 on D5, IF[0] still 1.
- ei at boundary k with a pending enabled request → int_req stays 0 until after boundary k+1. di on the same strobe as ei → ime stays 0.
- Write IF = 0x00 on the same strobe as an irq_in[3] pulse → IF reads 0xE8.
- Assert reset low during D3 → int_req = 0, vector_valid = 0, vector = 0x0000, IF and IE cleared.
